// File: rtl/apb_pkg.sv
// Shared definitions for the APB timer slave.
// Register byte offsets and CTRL bit positions.
package apb_pkg;

  localparam logic [4:0] CTRL_OFS     = 5'h00;
  localparam logic [4:0] LOAD_OFS     = 5'h04;
  localparam logic [4:0] COUNT_OFS    = 5'h08;
  localparam logic [4:0] STATUS_OFS   = 5'h0C;
  localparam logic [4:0] PRESCALE_OFS = 5'h10;

  localparam int unsigned EN_BIT = 0;
  localparam int unsigned AR_BIT = 1;
  localparam int unsigned IE_BIT = 2;

endpackage

// File: rtl/apb_prescaler.sv
// Prescaler for the APB timer.
// Emits one tick every prescale_i+1 enabled cycles.
module apb_prescaler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] prescale_i,
  output logic       tick_o
);

  logic [7:0] pre_cnt_q;
  logic [7:0] pre_cnt_d;

  assign tick_o = en_i & (pre_cnt_q == prescale_i);

  // A prescale value lowered below pre_cnt lets the counter wrap through 8'hFF.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr_i) begin
      pre_cnt_d = 8'h00;
    end else if (tick_o) begin
      pre_cnt_d = 8'h00;
    end else if (en_i) begin
      pre_cnt_d = pre_cnt_q + 8'h01;
    end else begin
      pre_cnt_d = pre_cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cnt_q <= 8'h00;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/apb_timer_slave.sv
// APB down-counter timer with prescaler, auto-reload and level interrupt.
// Zero-wait-state slave selected by one bit of the bridge PSEL bus.
module apb_timer_slave
  import apb_pkg::*;
#(
  parameter int SEL_IDX = 0,
  parameter int CNT_W   = 32
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [2:0]  PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        IRQ
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             en_q, en_d;
  logic             ar_q, ar_d;
  logic             ie_q, ie_d;
  logic             expired_q, expired_d;
  logic [7:0]       prescale_q, prescale_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       sel_s;
  logic       wr_s;
  logic [4:0] ofs_s;
  logic       wr_ctrl_s;
  logic       start_s;
  logic       tick_s;
  logic       expire_s;
  logic       unused_s;

  assign sel_s     = PSEL[SEL_IDX];
  assign wr_s      = sel_s & PENABLE & PWRITE;
  assign ofs_s     = {PADDR[4:2], 2'b00};
  assign wr_ctrl_s = wr_s & (ofs_s == CTRL_OFS);
  assign start_s   = wr_ctrl_s & PWDATA[EN_BIT] & ~en_q;
  assign expire_s  = tick_s & (count_q == '0);
  assign unused_s  = ^{PADDR, PWDATA, PSEL};

  apb_prescaler u_prescaler (
    .clk_i      (HCLK),
    .rst_i      (HRESET),
    .en_i       (en_q),
    .clr_i      (start_s),
    .prescale_i (prescale_q),
    .tick_o     (tick_s)
  );

  // Bus writes override hardware EN clear; expiry set overrides W1C.
  always_comb begin
    en_d       = en_q;
    ar_d       = ar_q;
    ie_d       = ie_q;
    expired_d  = expired_q;
    prescale_d = prescale_q;
    load_d     = load_q;
    count_d    = count_q;

    if (start_s) begin
      count_d = load_q;
    end else if (tick_s) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_ONE;
      end else if (ar_q) begin
        count_d = load_q;
      end else begin
        count_d = count_q;
        en_d    = 1'b0;
      end
    end else begin
      count_d = count_q;
    end

    if (wr_ctrl_s) begin
      en_d = PWDATA[EN_BIT];
      ar_d = PWDATA[AR_BIT];
      ie_d = PWDATA[IE_BIT];
    end else begin
      ar_d = ar_q;
    end

    if (wr_s && (ofs_s == LOAD_OFS)) begin
      load_d = PWDATA[CNT_W-1:0];
    end else begin
      load_d = load_q;
    end

    if (wr_s && (ofs_s == PRESCALE_OFS)) begin
      prescale_d = PWDATA[7:0];
    end else begin
      prescale_d = prescale_q;
    end

    if (expire_s) begin
      expired_d = 1'b1;
    end else if (wr_s && (ofs_s == STATUS_OFS) && PWDATA[0]) begin
      expired_d = 1'b0;
    end else begin
      expired_d = expired_q;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      en_q       <= 1'b0;
      ar_q       <= 1'b0;
      ie_q       <= 1'b0;
      expired_q  <= 1'b0;
      prescale_q <= 8'h00;
      load_q     <= '0;
      count_q    <= '0;
    end else begin
      en_q       <= en_d;
      ar_q       <= ar_d;
      ie_q       <= ie_d;
      expired_q  <= expired_d;
      prescale_q <= prescale_d;
      load_q     <= load_d;
      count_q    <= count_d;
    end
  end

  // Read data is zero unless this slave is addressed for a read, so slaves can be OR-ed.
  always_comb begin
    PRDATA = 32'h0000_0000;
    if (sel_s && !PWRITE) begin
      case (ofs_s)
        CTRL_OFS:     PRDATA = {29'h0, ie_q, ar_q, en_q};
        LOAD_OFS:     PRDATA = 32'(load_q);
        COUNT_OFS:    PRDATA = 32'(count_q);
        STATUS_OFS:   PRDATA = {31'h0, expired_q};
        PRESCALE_OFS: PRDATA = {24'h0, prescale_q};
        default:      PRDATA = 32'h0000_0000;
      endcase
    end else begin
      PRDATA = 32'h0000_0000;
    end
  end

  assign IRQ = expired_q & ie_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: expected read data is queued
// as each read is issued and compared when PRDATA is sampled.
module tb_apb_timer_slave;
  import apb_pkg::*;

  localparam int         SEL       = 1;
  localparam logic [2:0] MY_SEL    = 3'b010;
  localparam logic [2:0] OTHER_SEL = 3'b100;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [2:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        IRQ;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  apb_timer_slave #(.SEL_IDX(SEL), .CNT_W(32)) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .IRQ     (IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic idle_bus();
    PSEL = 3'b000; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; PWDATA = 32'h0;
  endtask

  // Setup-phase read, 2 time units, stays inside the current cycle.
  task automatic rd(input logic [2:0] psel, input logic [4:0] ofs, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    exp_q.push_back(exp);
    PSEL = psel; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {27'h0, ofs};
    #2;
    e = exp_q.pop_front();
    chk(tag, PRDATA, e);
    PSEL = 3'b000;
  endtask

  task automatic wr(input logic [2:0] psel, input logic [4:0] ofs, input logic [31:0] data);
    PSEL = psel; PADDR = {27'h0, ofs}; PWRITE = 1'b1; PWDATA = data; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    idle_bus();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle_bus();
    HRESET = 1'b1;
    cyc(2);
    rd(MY_SEL, CTRL_OFS, 32'h0, "rst_ctrl");
    rd(MY_SEL, COUNT_OFS, 32'h0, "rst_count");
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    HRESET = 1'b0;
    cyc(1);

    // Reset asserted mid-count
    wr(MY_SEL, PRESCALE_OFS, 32'd10);
    wr(MY_SEL, LOAD_OFS, 32'd5);
    wr(MY_SEL, CTRL_OFS, 32'h7);
    rd(MY_SEL, COUNT_OFS, 32'd5, "mid_count");
    rd(MY_SEL, CTRL_OFS, 32'h7, "mid_ctrl");
    cyc(1);
    HRESET = 1'b1;
    #1;
    rd(MY_SEL, CTRL_OFS, 32'h0, "rsta_ctrl");
    rd(MY_SEL, LOAD_OFS, 32'h0, "rsta_load");
    rd(MY_SEL, COUNT_OFS, 32'h0, "rsta_count");
    cyc(1);
    rd(MY_SEL, STATUS_OFS, 32'h0, "rsta_status");
    rd(MY_SEL, PRESCALE_OFS, 32'h0, "rsta_pre");
    chk("rsta_irq", {31'h0, IRQ}, 32'h0);
    HRESET = 1'b0;
    cyc(1);
    rd(MY_SEL, CTRL_OFS, 32'h0, "rstr_ctrl");
    rd(MY_SEL, LOAD_OFS, 32'h0, "rstr_load");
    rd(MY_SEL, COUNT_OFS, 32'h0, "rstr_count");
    cyc(1);
    rd(MY_SEL, STATUS_OFS, 32'h0, "rstr_status");
    rd(MY_SEL, PRESCALE_OFS, 32'h0, "rstr_pre");
    chk("rstr_irq", {31'h0, IRQ}, 32'h0);

    // One-shot, PRESCALE=0, LOAD=3
    wr(MY_SEL, PRESCALE_OFS, 32'd0);
    wr(MY_SEL, LOAD_OFS, 32'd3);
    wr(MY_SEL, CTRL_OFS, 32'h1);
    for (int i = 0; i < 4; i++) begin
      rd(MY_SEL, COUNT_OFS, 32'(3 - i), "os_count");
      rd(MY_SEL, STATUS_OFS, 32'h0, "os_status_pre");
      cyc(1);
    end
    rd(MY_SEL, STATUS_OFS, 32'h1, "os_expired");
    rd(MY_SEL, CTRL_OFS, 32'h0, "os_en_clr");
    rd(MY_SEL, COUNT_OFS, 32'h0, "os_count0");
    cyc(3);
    rd(MY_SEL, COUNT_OFS, 32'h0, "os_hold0");
    wr(MY_SEL, STATUS_OFS, 32'h1);
    rd(MY_SEL, STATUS_OFS, 32'h0, "os_w1c");

    // Auto-reload with IRQ, PRESCALE=1, LOAD=2
    wr(MY_SEL, PRESCALE_OFS, 32'd1);
    wr(MY_SEL, LOAD_OFS, 32'd2);
    wr(MY_SEL, CTRL_OFS, 32'h7);
    rd(MY_SEL, COUNT_OFS, 32'd2, "ar_start");
    chk("ar_irq0", {31'h0, IRQ}, 32'h0);
    cyc(5);
    rd(MY_SEL, COUNT_OFS, 32'd0, "ar_c0");
    chk("ar_irq_c5", {31'h0, IRQ}, 32'h0);
    cyc(1);
    chk("ar_irq_rise", {31'h0, IRQ}, 32'h1);
    rd(MY_SEL, COUNT_OFS, 32'd2, "ar_reload");
    rd(MY_SEL, STATUS_OFS, 32'h1, "ar_status");
    wr(MY_SEL, STATUS_OFS, 32'h1);
    chk("ar_irq_clr", {31'h0, IRQ}, 32'h0);
    rd(MY_SEL, COUNT_OFS, 32'd1, "ar_run");
    cyc(3);
    chk("ar_irq_p5", {31'h0, IRQ}, 32'h0);
    rd(MY_SEL, COUNT_OFS, 32'd0, "ar_c0b");
    cyc(1);
    chk("ar_irq_p6", {31'h0, IRQ}, 32'h1);
    rd(MY_SEL, COUNT_OFS, 32'd2, "ar_reload2");

    // W1C on the same edge as an expiry: set wins
    cyc(4);
    wr(MY_SEL, STATUS_OFS, 32'h1);
    rd(MY_SEL, STATUS_OFS, 32'h1, "sim_set_wins");
    chk("sim_irq", {31'h0, IRQ}, 32'h1);
    rd(MY_SEL, COUNT_OFS, 32'd2, "sim_count");
    wr(MY_SEL, STATUS_OFS, 32'h1);
    rd(MY_SEL, STATUS_OFS, 32'h0, "sim_w1c_after");
    chk("sim_irq_clr", {31'h0, IRQ}, 32'h0);
    wr(MY_SEL, CTRL_OFS, 32'h0);

    // LOAD change while running, then stop/freeze
    wr(MY_SEL, STATUS_OFS, 32'h1);
    wr(MY_SEL, PRESCALE_OFS, 32'd0);
    wr(MY_SEL, LOAD_OFS, 32'd3);
    wr(MY_SEL, CTRL_OFS, 32'h3);
    rd(MY_SEL, COUNT_OFS, 32'd3, "ld_start");
    wr(MY_SEL, LOAD_OFS, 32'd10);
    rd(MY_SEL, COUNT_OFS, 32'd1, "ld_run");
    rd(MY_SEL, LOAD_OFS, 32'd10, "ld_load");
    cyc(1);
    rd(MY_SEL, COUNT_OFS, 32'd0, "ld_c0");
    rd(MY_SEL, STATUS_OFS, 32'h0, "ld_st0");
    cyc(1);
    rd(MY_SEL, COUNT_OFS, 32'd10, "ld_reload");
    rd(MY_SEL, STATUS_OFS, 32'h1, "ld_st1");
    wr(MY_SEL, STATUS_OFS, 32'h1);
    rd(MY_SEL, COUNT_OFS, 32'd8, "ld_c8");
    rd(MY_SEL, STATUS_OFS, 32'h0, "ld_st_clr");
    cyc(8);
    rd(MY_SEL, COUNT_OFS, 32'd0, "ld_p11_c0");
    rd(MY_SEL, STATUS_OFS, 32'h0, "ld_p11_st0");
    cyc(1);
    rd(MY_SEL, COUNT_OFS, 32'd10, "ld_p11_reload");
    rd(MY_SEL, STATUS_OFS, 32'h1, "ld_p11_st1");
    cyc(2);
    rd(MY_SEL, COUNT_OFS, 32'd8, "stop_pre");
    wr(MY_SEL, CTRL_OFS, 32'h2);
    rd(MY_SEL, COUNT_OFS, 32'd6, "stop_count");
    rd(MY_SEL, CTRL_OFS, 32'h2, "stop_ctrl");
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      rd(MY_SEL, COUNT_OFS, 32'd6, "stop_frozen");
    end
    wr(MY_SEL, CTRL_OFS, 32'h3);
    rd(MY_SEL, COUNT_OFS, 32'd10, "restart_reload");
    wr(MY_SEL, CTRL_OFS, 32'h0);
    rd(MY_SEL, COUNT_OFS, 32'd8, "restop_count");

    // Decode and select isolation
    rd(OTHER_SEL, LOAD_OFS, 32'h0, "other_sel_rd");
    wr(OTHER_SEL, LOAD_OFS, 32'h33);
    rd(MY_SEL, LOAD_OFS, 32'd10, "other_sel_wr");
    PSEL = MY_SEL; PWRITE = 1'b1; PADDR = {27'h0, LOAD_OFS}; PWDATA = 32'h55; PENABLE = 1'b0;
    cyc(3);
    idle_bus();
    rd(MY_SEL, LOAD_OFS, 32'd10, "setup_only_wr");
    wr(MY_SEL, 5'h18, 32'hFFFF_FFFF);
    wr(MY_SEL, COUNT_OFS, 32'h77);
    rd(MY_SEL, CTRL_OFS, 32'h0, "hole_ctrl");
    rd(MY_SEL, LOAD_OFS, 32'd10, "hole_load");
    rd(MY_SEL, COUNT_OFS, 32'd8, "ro_count");
    cyc(1);
    rd(MY_SEL, STATUS_OFS, 32'h1, "hole_status");
    rd(MY_SEL, PRESCALE_OFS, 32'h0, "hole_pre");
    rd(MY_SEL, 5'h18, 32'h0, "hole_rd18");
    rd(MY_SEL, 5'h14, 32'h0, "hole_rd14");
    wr(MY_SEL, PRESCALE_OFS, 32'h1FF);
    rd(MY_SEL, PRESCALE_OFS, 32'hFF, "pre_mask");
    chk("irq_masked", {31'h0, IRQ}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
